riscv_run_ctrl: RTL



---
 rtl/riscv_run_pkg.sv | 21 ++
 rtl/riscv_run_trace.sv | 40 ++++
 rtl/riscv_run_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_run_pkg.sv
// Shared definitions for the riscv_top run controller and its optional PC trace.
// Holds the controller state encoding, trace buffer geometry and a width helper.
// No ports; imported by riscv_run_ctrl and riscv_run_trace.
package riscv_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam int TRACE_DEPTH = 8;
  localparam int TRACE_IDX_W = 3;

  // Bits needed to hold values 0..n (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/riscv_run_trace.sv
// PC trace ring buffer: records the snooped PC once per RUN cycle, last 8 entries.
// Ports: clk/rst (async active-low), clr (sync clear), wr_en/wr_addr (write port),
//        rd_idx/rd_addr (combinational read, idx 0 = most recent, k = k entries back).
module riscv_run_trace
  import riscv_run_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [TRACE_IDX_W-1:0] rd_idx,
  output logic [ADDR_W-1:0]      rd_addr
);

  logic [ADDR_W-1:0]      mem [TRACE_DEPTH];
  logic [TRACE_IDX_W-1:0] wptr;
  logic [TRACE_IDX_W-1:0] rd_ptr;

  // Clearing every entry (not just the pointer) is what makes unwritten slots read 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
    end else if (clr) begin
      for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
    end else if (wr_en) begin
      mem[wptr] <= wr_addr;
      wptr      <= wptr + TRACE_IDX_W'(1);
    end
  end

  // wptr points at the next free slot; modulo-8 arithmetic walks back from there.
  assign rd_ptr  = wptr - TRACE_IDX_W'(1) - rd_idx;
  assign rd_addr = mem[rd_ptr];

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for riscv_top: sequences core reset, counts RUN cycles and
// ends a run on PC self-loop (halt) or cycle budget (timeout). Optional PC trace
// ring buffer when RISCV_RUN_TRACE_EN is defined.
// Ports: clk, rst (async active-low), start (pulse, honoured in IDLE/DONE),
//        addr_in (snooped PC); outputs core_rst (active-low core reset), running,
//        done, halted, timeout, cycles -- all registered.
//        With RISCV_RUN_TRACE_EN: trace_idx in, trace_addr out.
module riscv_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 100,
  parameter int HALT_REPEAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles
`ifdef RISCV_RUN_TRACE_EN
  ,
  input  logic [TRACE_IDX_W-1:0] trace_idx,
  output logic [ADDR_W-1:0]      trace_addr
`endif
);

  localparam int HOLD_W = cnt_width(RST_CYCLES);
  localparam int RPT_W  = cnt_width(HALT_REPEAT);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_MAX   = RPT_W'(HALT_REPEAT);
  // HALT_REPEAT equal addresses span HALT_REPEAT-1 matches; halt fires on the
  // match that brings the count to HALT_REPEAT-1, i.e. when the count before it
  // is already HALT_REPEAT-2.
  localparam logic [RPT_W-1:0]  RPT_THR   = RPT_W'((HALT_REPEAT > 1) ? HALT_REPEAT - 2 : 0);

  run_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [RPT_W-1:0]  rpt_cnt, rpt_nxt;
  logic [ADDR_W-1:0] prev_addr, prev_nxt;
  logic [CNT_W-1:0]  cycles_nxt;
  logic              core_rst_nxt, running_nxt, done_nxt, halted_nxt, timeout_nxt;

  logic first_run;
  logic addr_match;
  logic halt_hit;
  logic timeout_hit;

  // cycles is cleared on RUN entry and cannot wrap inside RUN, so zero marks the
  // first RUN cycle, where prev_addr still holds a stale value.
  assign first_run   = (cycles == '0);
  assign addr_match  = !first_run && (addr_in == prev_addr);
  assign halt_hit    = (HALT_REPEAT != 0) && addr_match && (rpt_cnt >= RPT_THR);
  assign timeout_hit = (cycles == CYC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      rpt_cnt   <= '0;
      prev_addr <= '0;
      cycles    <= '0;
      core_rst  <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      rpt_cnt   <= rpt_nxt;
      prev_addr <= prev_nxt;
      cycles    <= cycles_nxt;
      core_rst  <= core_rst_nxt;
      running   <= running_nxt;
      done      <= done_nxt;
      halted    <= halted_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    rpt_nxt      = rpt_cnt;
    prev_nxt     = prev_addr;
    cycles_nxt   = cycles;
    core_rst_nxt = core_rst;
    running_nxt  = running;
    done_nxt     = done;
    halted_nxt   = halted;
    timeout_nxt  = timeout;

    case (state)
      IDLE: begin
        core_rst_nxt = 1'b0;
        if (start) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_LOAD;
        end
      end

      HOLD: begin
        core_rst_nxt = 1'b0;
        if (hold_cnt == '0) begin
          state_nxt    = RUN;
          core_rst_nxt = 1'b1;
          running_nxt  = 1'b1;
          cycles_nxt   = '0;
          rpt_nxt      = '0;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end

      RUN: begin
        prev_nxt = addr_in;
        if (addr_match) begin
          rpt_nxt = (rpt_cnt == RPT_MAX) ? rpt_cnt : rpt_cnt + RPT_W'(1);
        end else begin
          rpt_nxt = '0;
        end

        // Halt outranks timeout when both land on the same cycle. The exit
        // cycle does not increment, so cycles shows the last RUN cycle index.
        if (halt_hit) begin
          state_nxt   = DONE;
          running_nxt = 1'b0;
          done_nxt    = 1'b1;
          halted_nxt  = 1'b1;
        end else if (timeout_hit) begin
          state_nxt   = DONE;
          running_nxt = 1'b0;
          done_nxt    = 1'b1;
          timeout_nxt = 1'b1;
        end else begin
          cycles_nxt = cycles + CNT_W'(1);
        end
      end

      DONE: begin
        // Core keeps running out of reset here; its outputs are simply ignored.
        if (start) begin
          state_nxt    = HOLD;
          hold_nxt     = HOLD_LOAD;
          core_rst_nxt = 1'b0;
          done_nxt     = 1'b0;
          halted_nxt   = 1'b0;
          timeout_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef RISCV_RUN_TRACE_EN
  logic trace_wr;
  logic trace_clr;

  assign trace_wr  = (state == RUN);
  assign trace_clr = start && ((state == IDLE) || (state == DONE));

  riscv_run_trace #(
    .ADDR_W (ADDR_W)
  ) u_trace (
    .clk     (clk),
    .rst     (rst),
    .clr     (trace_clr),
    .wr_en   (trace_wr),
    .wr_addr (addr_in),
    .rd_idx  (trace_idx),
    .rd_addr (trace_addr)
  );
`endif

endmodule
